// File: rtl/vx_commit_arb_pkg.sv
// ---------------------------------------------------------------------------
// vx_commit_arb_pkg
// Shared types and constants for the per-issue-slot commit arbiter:
//   - geometry constants (units, threads, widths)
//   - execute-unit id enum (index order of the commit streams)
//   - commit beat struct carried through the output buffer
//   - small helpers: lane popcount and round-robin successor
// ---------------------------------------------------------------------------
package vx_commit_arb_pkg;

    localparam int NUM_UNITS   = 5;
    localparam int NUM_THREADS = 4;
    localparam int NW_BITS     = 2;
    localparam int XLEN        = 32;
    localparam int NR_BITS     = 6;
    localparam int UID_BITS    = $clog2(NUM_UNITS);
    localparam int CNT_BITS    = $clog2(NUM_THREADS) + 1;

    typedef enum logic [UID_BITS-1:0] {
        EX_ALU = 3'd0,
        EX_LSU = 3'd1,
        EX_TMA = 3'd2,
        EX_FPU = 3'd3,
        EX_SFU = 3'd4
    } ex_unit_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [NW_BITS-1:0]          wid;
        logic [NUM_THREADS-1:0]      tmask;
        logic [XLEN-1:0]             pc;
        logic                        wb;
        logic [NR_BITS-1:0]          rd;
        logic [NUM_THREADS*XLEN-1:0] data;
        logic                        sop;
        logic                        eop;
    } commit_beat_t;

    // Number of active lanes in a thread mask.
    function automatic logic [CNT_BITS-1:0] popcount(input logic [NUM_THREADS-1:0] m);
        logic [CNT_BITS-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cnt = cnt + CNT_BITS'(m[i]);
        end
        return cnt;
    endfunction

    // Next unit id in round-robin order, wrapping at NUM_UNITS.
    function automatic logic [UID_BITS-1:0] next_uid(input logic [UID_BITS-1:0] u);
        return (u == UID_BITS'(NUM_UNITS - 1)) ? '0 : u + 1'b1;
    endfunction

endpackage

// File: rtl/vx_commit_arb_chk.sv
// ---------------------------------------------------------------------------
// vx_commit_arb_chk
// Protocol checker for the commit arbiter (simulation only, no outputs).
//   clk, reset          : clock and reset (checks disabled while reset)
//   in_valid/in_ready   : per-unit handshake
//   in_sop              : per-unit start-of-packet
//   i_locked/i_lock_uid : arbiter lock state
// ---------------------------------------------------------------------------
module vx_commit_arb_chk
    import vx_commit_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_UNITS-1:0] in_valid,
    input  logic [NUM_UNITS-1:0] in_ready,
    input  logic [NUM_UNITS-1:0] in_sop,
    input  logic                 i_locked,
    input  logic [UID_BITS-1:0]  i_lock_uid
);

    // Grant must be one-hot, and a locked unit must not restart a packet.
    always @(posedge clk) begin
        if (!reset) begin
            a_ready_onehot: assert ($onehot0(in_ready));
            a_no_sop_mid:   assert (!(i_locked && in_valid[i_lock_uid] && in_sop[i_lock_uid]));
        end
    end

endmodule

// File: rtl/vx_commit_skid.sv
// ---------------------------------------------------------------------------
// vx_commit_skid
// Generic 2-entry elastic buffer (FIFO) with registered storage.
//   clk, reset   : clock, asynchronous active-high reset (flushes contents)
//   i_push/i_data: write request and payload; ignored when full
//   o_space      : at least one free slot (depends only on buffer state)
//   o_valid/o_data: head entry; stable until popped
//   i_pop        : consumer accept of the head entry
// ---------------------------------------------------------------------------
module vx_commit_skid #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [DATAW-1:0] i_data,
    output logic             o_space,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data,
    input  logic             i_pop
);

    logic [DATAW-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & (r_count != 2'd2);
    assign w_do_pop  = i_pop  & (r_count != 2'd0);

    assign o_space = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];

    // Storage write; contents cleared on reset for deterministic outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; push+pop together leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vx_commit_arb.sv
// ---------------------------------------------------------------------------
// vx_commit_arb
// Commit arbiter: merges NUM_UNITS execute commit streams into one stream.
// Round-robin among units, locked to one unit from sop until eop so that
// multi-beat packets stay contiguous; 2-entry registered output buffer;
// per-cycle retire pulse with active-lane count.
//   in_*     : per-unit commit beats (packed, unit u at slice u)
//   in_ready : grant (combinational from buffer state, one-hot or zero)
//   out_*    : merged beat, out_uid = source unit
//   retire_valid/retire_cnt : eop beat handshaken in the previous cycle
// ---------------------------------------------------------------------------
module vx_commit_arb
    import vx_commit_arb_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_UNITS-1:0]                 in_valid,
    output logic [NUM_UNITS-1:0]                 in_ready,
    input  logic [NUM_UNITS*NW_BITS-1:0]         in_wid,
    input  logic [NUM_UNITS*NUM_THREADS-1:0]     in_tmask,
    input  logic [NUM_UNITS*XLEN-1:0]            in_pc,
    input  logic [NUM_UNITS-1:0]                 in_wb,
    input  logic [NUM_UNITS*NR_BITS-1:0]         in_rd,
    input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] in_data,
    input  logic [NUM_UNITS-1:0]                 in_sop,
    input  logic [NUM_UNITS-1:0]                 in_eop,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NW_BITS-1:0]                   out_wid,
    output logic [NUM_THREADS-1:0]               out_tmask,
    output logic [XLEN-1:0]                      out_pc,
    output logic                                 out_wb,
    output logic [NR_BITS-1:0]                   out_rd,
    output logic [NUM_THREADS*XLEN-1:0]          out_data,
    output logic                                 out_sop,
    output logic                                 out_eop,
    output logic [UID_BITS-1:0]                  out_uid,
    output logic                                 retire_valid,
    output logic [CNT_BITS-1:0]                  retire_cnt
);

    localparam int SKIDW = UID_BITS + $bits(commit_beat_t);

    commit_beat_t          w_unit_beat [NUM_UNITS];
    commit_beat_t          w_beat;
    commit_beat_t          w_out_beat;
    logic [UID_BITS-1:0]   w_grant;
    logic                  w_grant_en;
    logic [UID_BITS:0]     w_sum;
    logic [UID_BITS:0]     w_idx;
    logic                  w_hit;
    logic [NUM_UNITS-1:0]  w_ready;
    logic                  w_space;
    logic                  w_accept;
    logic                  w_out_fire;

    arb_state_e            r_state;
    logic [UID_BITS-1:0]   r_lock_uid;
    logic [UID_BITS-1:0]   r_rr_ptr;
    logic                  r_retire_valid;
    logic [CNT_BITS-1:0]   r_retire_cnt;

    // Unpack each unit's flat input slices into a beat struct.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            w_unit_beat[u].wid   = in_wid[u*NW_BITS +: NW_BITS];
            w_unit_beat[u].tmask = in_tmask[u*NUM_THREADS +: NUM_THREADS];
            w_unit_beat[u].pc    = in_pc[u*XLEN +: XLEN];
            w_unit_beat[u].wb    = in_wb[u];
            w_unit_beat[u].rd    = in_rd[u*NR_BITS +: NR_BITS];
            w_unit_beat[u].data  = in_data[u*NUM_THREADS*XLEN +: NUM_THREADS*XLEN];
            w_unit_beat[u].sop   = in_sop[u];
            w_unit_beat[u].eop   = in_eop[u];
        end
    end

    // Grant select: lock holder, else first valid unit at/after rr_ptr.
    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        w_grant    = '0;
        w_grant_en = 1'b0;
        w_sum      = '0;
        w_idx      = '0;
        w_hit      = 1'b0;
        if (r_state == ARB_LOCKED) begin
            w_grant    = r_lock_uid;
            w_grant_en = 1'b1;
        end else begin
            for (int i = NUM_UNITS - 1; i >= 0; i--) begin
                w_sum      = {1'b0, r_rr_ptr} + (UID_BITS+1)'(i);
                w_idx      = (w_sum >= (UID_BITS+1)'(NUM_UNITS)) ?
                             (w_sum - (UID_BITS+1)'(NUM_UNITS)) : w_sum;
                w_hit      = in_valid[w_idx[UID_BITS-1:0]];
                w_grant    = w_hit ? w_idx[UID_BITS-1:0] : w_grant;
                w_grant_en = w_grant_en | w_hit;
            end
        end
    end

    // Ready only to the granted unit, only with buffer space, never in reset.
    always_comb begin
        w_ready = '0;
        if (w_grant_en && w_space && !reset) begin
            w_ready[w_grant] = 1'b1;
        end else begin
            w_ready = '0;
        end
    end

    assign in_ready   = w_ready;
    assign w_accept   = |(w_ready & in_valid);
    assign w_beat     = w_unit_beat[w_grant];
    assign w_out_fire = out_valid & out_ready;

    vx_commit_skid #(
        .DATAW (SKIDW)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_data  ({w_grant, w_beat}),
        .o_space (w_space),
        .o_valid (out_valid),
        .o_data  ({out_uid, w_out_beat}),
        .i_pop   (out_ready)
    );

    assign out_wid   = w_out_beat.wid;
    assign out_tmask = w_out_beat.tmask;
    assign out_pc    = w_out_beat.pc;
    assign out_wb    = w_out_beat.wb;
    assign out_rd    = w_out_beat.rd;
    assign out_data  = w_out_beat.data;
    assign out_sop   = w_out_beat.sop;
    assign out_eop   = w_out_beat.eop;

    // Arbitration FSM: lock on a non-eop accept, release and advance on eop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_lock_uid <= '0;
            r_rr_ptr   <= UID_BITS'(EX_ALU);
        end else if (w_accept) begin
            if (w_beat.eop) begin
                r_state  <= ARB_IDLE;
                r_rr_ptr <= next_uid(w_grant);
            end else begin
                r_state    <= ARB_LOCKED;
                r_lock_uid <= w_grant;
            end
        end
    end

    // Retire pulse follows the output handshake of an eop beat by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire_valid <= 1'b0;
            r_retire_cnt   <= '0;
        end else begin
            r_retire_valid <= w_out_fire & w_out_beat.eop;
            r_retire_cnt   <= (w_out_fire & w_out_beat.eop) ? popcount(w_out_beat.tmask) : '0;
        end
    end

    assign retire_valid = r_retire_valid;
    assign retire_cnt   = r_retire_cnt;

    vx_commit_arb_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sop     (in_sop),
        .i_locked   (r_state == ARB_LOCKED),
        .i_lock_uid (r_lock_uid)
    );

endmodule

// File: tb/tb_vx_commit_arb.sv
// ---------------------------------------------------------------------------
// tb_vx_commit_arb
// Directed bench for vx_commit_arb: a table of per-cycle vectors
// {valid, sop, eop, out_ready -> in_ready, out_valid, out_uid, retire}
// plus hand-written sequences for backpressure and mid-packet reset.
// Per-unit payload is fixed so out_pc/out_data/out_tmask follow from out_uid.
// ---------------------------------------------------------------------------
module tb_vx_commit_arb;
    import vx_commit_arb_pkg::*;

    logic                                  clk = 1'b0;
    logic                                  reset;
    logic [NUM_UNITS-1:0]                  in_valid;
    logic [NUM_UNITS-1:0]                  in_ready;
    logic [NUM_UNITS*NW_BITS-1:0]          in_wid;
    logic [NUM_UNITS*NUM_THREADS-1:0]      in_tmask;
    logic [NUM_UNITS*XLEN-1:0]             in_pc;
    logic [NUM_UNITS-1:0]                  in_wb;
    logic [NUM_UNITS*NR_BITS-1:0]          in_rd;
    logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] in_data;
    logic [NUM_UNITS-1:0]                  in_sop;
    logic [NUM_UNITS-1:0]                  in_eop;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [NW_BITS-1:0]                    out_wid;
    logic [NUM_THREADS-1:0]                out_tmask;
    logic [XLEN-1:0]                       out_pc;
    logic                                  out_wb;
    logic [NR_BITS-1:0]                    out_rd;
    logic [NUM_THREADS*XLEN-1:0]           out_data;
    logic                                  out_sop;
    logic                                  out_eop;
    logic [UID_BITS-1:0]                   out_uid;
    logic                                  retire_valid;
    logic [CNT_BITS-1:0]                   retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] tm [NUM_UNITS] = '{4'b1111, 4'b0001, 4'b0011, 4'b0111, 4'b1011};

    typedef struct {
        logic [4:0] v;
        logic [4:0] s;
        logic [4:0] e;
        logic       ordy;
        logic [4:0] rdy;
        logic       ov;
        logic [2:0] uid;
        logic       rv;
        logic [2:0] rc;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    vx_commit_arb dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wid(in_wid), .in_tmask(in_tmask), .in_pc(in_pc), .in_wb(in_wb),
        .in_rd(in_rd), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wid(out_wid), .out_tmask(out_tmask), .out_pc(out_pc), .out_wb(out_wb),
        .out_rd(out_rd), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_uid(out_uid), .retire_valid(retire_valid), .retire_cnt(retire_cnt)
    );

    function automatic logic [31:0] exp_pc(input int u);
        return 32'h0000_1000 + 32'(u) * 32'd16;
    endfunction

    function automatic logic [127:0] exp_data(input int u);
        logic [127:0] r;
        for (int l = 0; l < NUM_THREADS; l++) begin
            r[l*32 +: 32] = 32'hA000_0000 | (32'(u) << 8) | 32'(l);
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [4:0] v, input logic [4:0] s, input logic [4:0] e,
                                input logic ordy, input logic [4:0] rdy, input logic ov,
                                input logic [2:0] uid, input logic rv, input logic [2:0] rc);
        vec_t t;
        t.v = v; t.s = s; t.e = e; t.ordy = ordy; t.rdy = rdy;
        t.ov = ov; t.uid = uid; t.rv = rv; t.rc = rc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v, input logic [4:0] s, input logic [4:0] e, input logic r);
        in_valid  = v;
        in_sop    = s;
        in_eop    = e;
        out_ready = r;
    endtask

    task automatic cyc_chk(input string tag, input logic [4:0] rdy, input logic ov,
                           input logic [2:0] uid, input logic rv, input logic [2:0] rc);
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(rdy));
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(ov));
        if (ov) begin
            chk({tag, ".out_uid"}, 128'(out_uid), 128'(uid));
            chk({tag, ".out_pc"}, 128'(out_pc), 128'(exp_pc(int'(uid))));
            chk({tag, ".out_tmask"}, 128'(out_tmask), 128'(tm[uid]));
            chk({tag, ".out_wid"}, 128'(out_wid), 128'(2'(uid)));
            chk({tag, ".out_rd"}, 128'(out_rd), 128'(6'(uid) + 6'd1));
            chk({tag, ".out_data"}, out_data, exp_data(int'(uid)));
        end
        chk({tag, ".retire_valid"}, 128'(retire_valid), 128'(rv));
        chk({tag, ".retire_cnt"}, 128'(retire_cnt), 128'(rc));
    endtask

    // Apply one cycle of inputs, check just after they settle, then clock.
    task automatic run(input string tag, input vec_t t);
        drive(t.v, t.s, t.e, t.ordy);
        #1;
        cyc_chk(tag, t.rdy, t.ov, t.uid, t.rv, t.rc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Main vectors: RR single beats, 3-beat lock, wrap-around.
        tbl.push_back(mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b00001, 1'b0, 3'd0, 1'b0, 3'd0));
        tbl.push_back(mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b00100, 1'b1, 3'd0, 1'b0, 3'd0));
        tbl.push_back(mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b10000, 1'b1, 3'd2, 1'b1, 3'd4));
        tbl.push_back(mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b00001, 1'b1, 3'd4, 1'b1, 3'd2));
        tbl.push_back(mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b00100, 1'b1, 3'd0, 1'b1, 3'd3));
        tbl.push_back(mk(5'b10101, 5'b10101, 5'b10101, 1'b1, 5'b10000, 1'b1, 3'd2, 1'b1, 3'd4));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd4, 1'b1, 3'd2));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b1, 3'd3));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0));
        tbl.push_back(mk(5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b0, 3'd0, 1'b0, 3'd0));
        tbl.push_back(mk(5'b00011, 5'b00011, 5'b00001, 1'b1, 5'b00010, 1'b1, 3'd0, 1'b0, 3'd0));
        tbl.push_back(mk(5'b00011, 5'b00001, 5'b00001, 1'b1, 5'b00010, 1'b1, 3'd1, 1'b1, 3'd4));
        tbl.push_back(mk(5'b00011, 5'b00001, 5'b00011, 1'b1, 5'b00010, 1'b1, 3'd1, 1'b0, 3'd0));
        tbl.push_back(mk(5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b1, 3'd1, 1'b0, 3'd0));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd0, 1'b1, 3'd1));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b1, 3'd4));
        tbl.push_back(mk(5'b01000, 5'b01000, 5'b01000, 1'b1, 5'b01000, 1'b0, 3'd0, 1'b0, 3'd0));
        tbl.push_back(mk(5'b10000, 5'b10000, 5'b10000, 1'b1, 5'b10000, 1'b1, 3'd3, 1'b0, 3'd0));
        tbl.push_back(mk(5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b1, 3'd4, 1'b1, 3'd3));
        tbl.push_back(mk(5'b00011, 5'b00011, 5'b00011, 1'b1, 5'b00010, 1'b1, 3'd0, 1'b1, 3'd3));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd1, 1'b1, 3'd4));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b1, 3'd1));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0));

        for (int u = 0; u < NUM_UNITS; u++) begin
            in_wid[u*NW_BITS +: NW_BITS]                  = 2'(u);
            in_tmask[u*NUM_THREADS +: NUM_THREADS]        = tm[u];
            in_pc[u*XLEN +: XLEN]                         = exp_pc(u);
            in_wb[u]                                      = 1'b1;
            in_rd[u*NR_BITS +: NR_BITS]                   = 6'(u + 1);
            in_data[u*NUM_THREADS*XLEN +: NUM_THREADS*XLEN] = exp_data(u);
        end

        // Reset state, with every unit requesting.
        reset = 1'b1;
        drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        cyc_chk("reset", 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0);
        reset = 1'b0;

        foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

        // Backpressure: rr_ptr=2, out_ready low for 4 cycles, then drain.
        run("bp0", mk(5'b10101, 5'b10101, 5'b10101, 1'b0, 5'b00100, 1'b0, 3'd0, 1'b0, 3'd0));
        run("bp1", mk(5'b10101, 5'b10101, 5'b10101, 1'b0, 5'b10000, 1'b1, 3'd2, 1'b0, 3'd0));
        run("bp2", mk(5'b10101, 5'b10101, 5'b10101, 1'b0, 5'b00000, 1'b1, 3'd2, 1'b0, 3'd0));
        run("bp3", mk(5'b10101, 5'b10101, 5'b10101, 1'b0, 5'b00000, 1'b1, 3'd2, 1'b0, 3'd0));
        run("bp4", mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd2, 1'b0, 3'd0));
        run("bp5", mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd4, 1'b1, 3'd2));
        run("bp6", mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b1, 3'd3));
        run("bp7", mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0));

        // Reset while locked on unit 3 with both buffer slots filled.
        run("rl0", mk(5'b01000, 5'b01000, 5'b00000, 1'b0, 5'b01000, 1'b0, 3'd0, 1'b0, 3'd0));
        run("rl1", mk(5'b01001, 5'b00001, 5'b00001, 1'b0, 5'b01000, 1'b1, 3'd3, 1'b0, 3'd0));
        drive(5'b01001, 5'b00001, 5'b00001, 1'b0);
        #1;
        cyc_chk("rl2", 5'b00000, 1'b1, 3'd3, 1'b0, 3'd0);
        #1;
        reset = 1'b1;
        #1;
        cyc_chk("rl_async", 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run("rl3", mk(5'b01001, 5'b01001, 5'b01001, 1'b1, 5'b00001, 1'b0, 3'd0, 1'b0, 3'd0));
        run("rl4", mk(5'b01001, 5'b01001, 5'b01001, 1'b1, 5'b01000, 1'b1, 3'd0, 1'b0, 3'd0));
        run("rl5", mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 3'd3, 1'b1, 3'd4));
        run("rl6", mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b1, 3'd3));
        run("rl7", mk(5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b0, 3'd0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
